// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and fetch FSM encoding for the MIPS front end
package mips_pkg;

    localparam logic [31:0] NOP_IR_DEF   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] FUNCT_JR   = 6'h08;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory request/ready port
interface if_stage_if;
    logic        IMREQ;
    logic [31:0] IMADDR;
    logic [31:0] IMRDATA;
    logic        IMRDY;

    modport master (output IMREQ, output IMADDR, input IMRDATA, input IMRDY);
    modport slave  (input IMREQ, input IMADDR, output IMRDATA, output IMRDY);
endinterface

// File: rtl/br_target.sv
// rtl/br_target.sv - redirect target select for the instruction in ID (jr > j > branch)
module br_target (
    input  logic [25:0] IDIR,
    input  logic [31:0] IDPC4,
    input  logic [31:0] RSVAL,
    input  logic        JUMP,
    input  logic        JR,
    output logic [31:0] TARGET
);

    always_comb begin
        TARGET = IDPC4 + {{14{IDIR[15]}}, IDIR[15:0], 2'b00};
        if (JR) begin
            TARGET = RSVAL;
        end else if (JUMP) begin
            TARGET = {IDPC4[31:28], IDIR[25:0], 2'b00};
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage: PC, IF/ID register, one-entry skid buffer and delayed redirect
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_IR   = NOP_IR_DEF
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        WPCIR,
    input  logic        BRANCH,
    input  logic        JUMP,
    input  logic        JR,
    input  logic [31:0] RSVAL,
    if_stage_if.master  imem,
    output logic [31:0] IDIR,
    output logic [31:0] IDPC4
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] idir_q, idir_d;
    logic [31:0] idpc4_q, idpc4_d;
    logic [31:0] bufir_q, bufir_d;
    logic [31:0] bufpc4_q, bufpc4_d;
    logic        redir_vld_q, redir_vld_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        imreq;
    logic        xfer;
    logic        redir;

    br_target u_br_target (
        .IDIR   (idir_q[25:0]),
        .IDPC4  (idpc4_q),
        .RSVAL  (RSVAL),
        .JUMP   (JUMP),
        .JR     (JR),
        .TARGET (target)
    );

    assign imreq    = (state_q == S_FETCH);
    assign xfer     = imreq && imem.IMRDY;
    assign redir    = BRANCH && !WPCIR;
    assign pc_plus4 = pc_q + 32'd4;

    assign imem.IMREQ  = imreq;
    assign imem.IMADDR = pc_q;
    assign IDIR        = idir_q;
    assign IDPC4       = idpc4_q;

    // A pending redirect outranks one arriving now; the latter is illegal anyway.
    always_comb begin
        next_pc = pc_plus4;
        if (redir_vld_q) begin
            next_pc = redir_pc_q;
        end else if (redir) begin
            next_pc = target;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        idir_d      = idir_q;
        idpc4_d     = idpc4_q;
        bufir_d     = bufir_q;
        bufpc4_d    = bufpc4_q;
        redir_vld_d = redir_vld_q;
        redir_pc_d  = redir_pc_q;

        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: if (xfer && WPCIR) state_d = S_FULL;
            S_FULL:  if (!WPCIR) state_d = S_FETCH;
            default: state_d = S_RST;
        endcase

        if (xfer) begin
            pc_d        = next_pc;
            redir_vld_d = 1'b0;
        end

        if (WPCIR) begin
            if (xfer) begin
                bufir_d  = imem.IMRDATA;
                bufpc4_d = pc_plus4;
            end
        end else if (state_q == S_FULL) begin
            idir_d  = bufir_q;
            idpc4_d = bufpc4_q;
        end else if (xfer) begin
            idir_d  = imem.IMRDATA;
            idpc4_d = pc_plus4;
        end else begin
            idir_d  = NOP_IR;
        end

        // Without a transfer the delay slot is either sitting in the buffer
        // (PC already past it) or still outstanding (hold target until fetched).
        if (redir && !xfer) begin
            if (state_q == S_FULL) begin
                pc_d = target;
            end else begin
                redir_vld_d = 1'b1;
                redir_pc_d  = target;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_RST;
            pc_q        <= RESET_PC;
            idir_q      <= NOP_IR;
            idpc4_q     <= RESET_PC;
            bufir_q     <= NOP_IR;
            bufpc4_q    <= RESET_PC;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            idir_q      <= idir_d;
            idpc4_q     <= idpc4_d;
            bufir_q     <= bufir_d;
            bufpc4_q    <= bufpc4_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;
    import mips_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wpcir = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] rsval = 32'h0;
    logic        rdy = 1'b0;
    logic [31:0] idir;
    logic [31:0] idpc4;
    logic [31:0] sp_addr = 32'hffff_fff0;
    logic [31:0] sp_word = 32'h0;
    logic        mon_en = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_id_q[$];

    logic [31:0] w_beq;
    logic [31:0] w_j;
    logic [31:0] w_jr;

    if_stage_if imem ();

    assign imem.IMRDY   = rdy;
    assign imem.IMRDATA = (imem.IMADDR == sp_addr) ? sp_word : imem.IMADDR;

    if_stage #(.RESET_PC(RPC), .NOP_IR(NOP)) dut (
        .CLK    (clk),
        .RSTN   (rstn),
        .WPCIR  (wpcir),
        .BRANCH (branch),
        .JUMP   (jump),
        .JR     (jr),
        .RSVAL  (rsval),
        .imem   (imem),
        .IDIR   (idir),
        .IDPC4  (idpc4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_id(input logic [31:0] ir, input logic [31:0] pc4);
        exp_id_q.push_back({ir, pc4});
    endtask

    task automatic do_reset(input logic [31:0] addr, input logic [31:0] word);
        rstn   = 1'b0;
        mon_en = 1'b0;
        wpcir  = 1'b0;
        branch = 1'b0;
        jump   = 1'b0;
        jr     = 1'b0;
        rsval  = 32'h0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_imreq", {31'd0, imem.IMREQ}, 32'd0);
            check("rst_idir", idir, NOP);
            step();
        end
        check("rst_idpc4", idpc4, RPC);
        sp_addr = addr;
        sp_word = word;
        rdy     = 1'b1;
        rstn    = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic drain_check();
        check("addr_q_left", exp_addr_q.size(), 32'd0);
        check("id_q_left", exp_id_q.size(), 32'd0);
        exp_addr_q.delete();
        exp_id_q.delete();
    endtask

    // Monitor: transfers are sampled mid-cycle, the IF/ID register just after the edge.
    initial begin
        logic        s_en;
        logic        s_stall;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            s_en    = mon_en;
            s_stall = wpcir;
            if (branch && !wpcir && dut.redir_vld_q) begin
                n_cmp++;
                n_mis++;
                $display("FAIL redir_overlap: second redirect while one pending at %0t", $time);
            end
            if (mon_en && imem.IMREQ && imem.IMRDY) begin
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL extra_xfer: got addr %08h expected none", imem.IMADDR);
                end else begin
                    check("imaddr", imem.IMADDR, exp_addr_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (s_en && !s_stall) begin
                if (exp_id_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL extra_id: got idir %08h expected none", idir);
                end else begin
                    e = exp_id_q.pop_front();
                    check("idir", idir, e[63:32]);
                    check("idpc4", idpc4, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        w_beq = {OP_BEQ, 5'd0, 5'd0, 16'd3};
        w_j   = {OP_J, 26'h010_0040};
        w_jr  = {OP_SPECIAL, 5'd31, 15'd0, FUNCT_JR};

        // Reset then straight-line stream, IMRDATA = IMADDR
        push_id(NOP, RPC);
        push_id(RPC, RPC + 32'd4);
        push_id(RPC + 32'd4, RPC + 32'd8);
        push_id(RPC + 32'd8, RPC + 32'd12);
        exp_addr_q.push_back(RPC);
        exp_addr_q.push_back(RPC + 32'd4);
        exp_addr_q.push_back(RPC + 32'd8);
        do_reset(32'hffff_fff0, 32'h0);
        step();
        check("first_imreq", {31'd0, imem.IMREQ}, 32'd1);
        check("first_imaddr", imem.IMADDR, RPC);
        step();
        step();
        step();
        mon_en = 1'b0;
        drain_check();

        // beq taken with zero-wait memory; reset lands mid-request
        push_id(NOP, RPC);
        push_id(w_beq, RPC + 32'd4);
        push_id(RPC + 32'd4, RPC + 32'd8);
        push_id(RPC + 32'h10, RPC + 32'h14);
        exp_addr_q.push_back(RPC);
        exp_addr_q.push_back(RPC + 32'd4);
        exp_addr_q.push_back(RPC + 32'h10);
        do_reset(RPC, w_beq);
        step();
        step();
        branch = 1'b1;
        step();
        branch = 1'b0;
        step();
        mon_en = 1'b0;
        drain_check();

        // j with three wait states on the delay slot
        push_id(NOP, RPC);
        push_id(w_j, RPC + 32'd4);
        push_id(NOP, RPC + 32'd4);
        push_id(NOP, RPC + 32'd4);
        push_id(NOP, RPC + 32'd4);
        push_id(RPC + 32'd4, RPC + 32'd8);
        push_id(32'h0040_0100, 32'h0040_0104);
        exp_addr_q.push_back(RPC);
        exp_addr_q.push_back(RPC + 32'd4);
        exp_addr_q.push_back(32'h0040_0100);
        do_reset(RPC, w_j);
        step();
        step();
        branch = 1'b1;
        jump   = 1'b1;
        rdy    = 1'b0;
        step();
        branch = 1'b0;
        jump   = 1'b0;
        check("wait_imaddr1", imem.IMADDR, RPC + 32'd4);
        step();
        check("wait_imaddr2", imem.IMADDR, RPC + 32'd4);
        step();
        rdy = 1'b1;
        step();
        step();
        mon_en = 1'b0;
        drain_check();

        // Stall fills the skid buffer with the delay slot, then jr on release
        push_id(NOP, RPC);
        push_id(w_jr, RPC + 32'd4);
        push_id(RPC + 32'd4, RPC + 32'd8);
        push_id(32'h0040_0200, 32'h0040_0204);
        exp_addr_q.push_back(RPC);
        exp_addr_q.push_back(RPC + 32'd4);
        exp_addr_q.push_back(32'h0040_0200);
        do_reset(RPC, w_jr);
        step();
        step();
        wpcir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_imreq", {31'd0, imem.IMREQ}, 32'd0);
            check("stall_idir", idir, w_jr);
        end
        wpcir  = 1'b0;
        jr     = 1'b1;
        branch = 1'b1;
        rsval  = 32'h0040_0200;
        step();
        jr     = 1'b0;
        branch = 1'b0;
        check("rel_imreq", {31'd0, imem.IMREQ}, 32'd1);
        check("jr_imaddr", imem.IMADDR, 32'h0040_0200);
        step();
        mon_en = 1'b0;
        drain_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
